adder_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared `adder8bit` datapath in the ALU. It accepts operand pairs from two independent requesters over valid/ready handshakes and grants one request at a time. It drives the adder from registered operands, captures sum/carry/overflow into a result register and returns them on a single response channel tagged with the requester ID.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/adder8bit.sv | 30 +++
 rtl/adder_arbiter.sv | 148 ++++++++++++++
 tb/tb_adder_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU constants: datapath width, adder_arbiter state
//               encoding and requester IDs.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } arb_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/adder8bit.sv
`default_nettype none
// ============================================================================
// Module      : adder8bit
// Description : Combinational adder producing sum, unsigned carry-out and
//               two's-complement signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adder8bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] w_full;

  // Widen by one bit so the carry falls out of the top of the addition.
  always_comb begin
    w_full   = {1'b0, a} + {1'b0, b};
    sum      = w_full[WIDTH-1:0];
    carry    = w_full[WIDTH];
    // Signed overflow: operands agree in sign but the result does not.
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]);
  end

endmodule : adder8bit
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Two-requester round-robin arbiter and sequencer for the shared
//               adder. One operation in flight at a time: accept, execute,
//               hold the registered response until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_sum,
  output logic              resp_carry,
  output logic              resp_overflow
);

  import alu_pkg::*;

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              grant_id_q, grant_id_d;
  logic              last_id_q, last_id_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_sum_q, resp_sum_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_overflow_q, resp_overflow_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_carry;
  logic              add_overflow;

  adder8bit #(
    .WIDTH (DATA_W)
  ) u_adder (
    .a        (op_a_q),
    .b        (op_b_q),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  // Next-state, grant selection and combinational ready outputs.
  always_comb begin
    state_d         = state_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    grant_id_d      = grant_id_q;
    last_id_d       = last_id_q;
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_sum_d      = resp_sum_q;
    resp_carry_d    = resp_carry_q;
    resp_overflow_d = resp_overflow_q;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is gated by rst so nothing is accepted during reset.
        if (!rst) begin
          // Requester 0 wins when alone, or under contention after a req1 grant.
          if (req0_valid && (!req1_valid || (last_id_q == ID_REQ1))) begin
            req0_ready = 1'b1;
            op_a_d     = req0_a;
            op_b_d     = req0_b;
            grant_id_d = ID_REQ0;
            last_id_d  = ID_REQ0;
            state_d    = S_EXEC;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            op_a_d     = req1_a;
            op_b_d     = req1_b;
            grant_id_d = ID_REQ1;
            last_id_d  = ID_REQ1;
            state_d    = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        resp_valid_d    = 1'b1;
        resp_id_d       = grant_id_q;
        resp_sum_d      = add_sum;
        resp_carry_d    = add_carry;
        resp_overflow_d = add_overflow;
        state_d         = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_a_q          <= '0;
      op_b_q          <= '0;
      grant_id_q      <= ID_REQ0;
      last_id_q       <= ID_REQ1;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= ID_REQ0;
      resp_sum_q      <= '0;
      resp_carry_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      grant_id_q      <= grant_id_d;
      last_id_q       <= last_id_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_sum_q      <= resp_sum_d;
      resp_carry_q    <= resp_carry_d;
      resp_overflow_q <= resp_overflow_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_sum      = resp_sum_q;
  assign resp_carry    = resp_carry_q;
  assign resp_overflow = resp_overflow_q;

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench for adder_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_sum;
  logic       resp_carry, resp_overflow;

  int checks = 0;
  int errors = 0;

  // Requester-side pending requests (held until granted).
  bit         p0_v, p1_v;
  logic [7:0] p0_a, p0_b, p1_a, p1_b;

  // Reference model: cycles since grant (0 free, 1 executing, 2 responding),
  // last granted requester, and the expected response.
  int m_phase;
  bit m_last;
  bit m_id;
  int m_sum, m_carry, m_ovf;
  int n_resp0, n_resp1;

  adder_arbiter #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_ready    (req1_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_sum      (resp_sum),
    .resp_carry    (resp_carry),
    .resp_overflow (resp_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference from plain integer math.
  task automatic compute(input int a, input int b);
    int sa, sb, s;
    sa      = (a >= 128) ? a - 256 : a;
    sb      = (b >= 128) ? b - 256 : b;
    s       = sa + sb;
    m_sum   = (a + b) % 256;
    m_carry = ((a + b) > 255) ? 1 : 0;
    m_ovf   = (s > 127 || s < -128) ? 1 : 0;
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model at the edge.
  task automatic step(input bit r, input bit rr);
    bit g0, g1;
    @(negedge clk);
    rst        = r;
    resp_ready = rr;
    req0_valid = p0_v;  req0_a = p0_a;  req0_b = p0_b;
    req1_valid = p1_v;  req1_a = p1_a;  req1_b = p1_b;
    #1;
    g0 = !r && (m_phase == 0) && p0_v && (!p1_v || m_last);
    g1 = !r && (m_phase == 0) && p1_v && !g0;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("ready_excl", req0_ready & req1_ready, 0);
    chk("resp_valid", resp_valid, (m_phase == 2));
    if (m_phase == 2) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_sum", resp_sum, m_sum);
      chk("resp_carry", resp_carry, m_carry);
      chk("resp_overflow", resp_overflow, m_ovf);
    end
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_last  = 1'b1;
    end else begin
      case (m_phase)
        0: if (g0 || g1) begin
             m_id   = g1;
             m_last = g1;
             if (g0) begin compute(p0_a, p0_b); p0_v = 1'b0; end
             else    begin compute(p1_a, p1_b); p1_v = 1'b0; end
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rr) begin
             m_phase = 0;
             if (m_id) n_resp1++; else n_resp0++;
           end
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    #2;
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_id"}, resp_id, 0);
    chk({tag, "_sum"}, resp_sum, 0);
    chk({tag, "_carry"}, resp_carry, 0);
    chk({tag, "_ovf"}, resp_overflow, 0);
  endtask

  initial begin
    logic [7:0] edge_a [4];
    logic [7:0] edge_b [4];
    int         r0;
    edge_a[0] = 8'hFF; edge_b[0] = 8'hFF;
    edge_a[1] = 8'h7F; edge_b[1] = 8'h01;
    edge_a[2] = 8'h80; edge_b[2] = 8'h80;
    edge_a[3] = 8'h00; edge_b[3] = 8'h00;

    p0_v = 0; p1_v = 0; p0_a = 0; p0_b = 0; p1_a = 0; p1_b = 0;
    m_phase = 0; m_last = 1; m_id = 0; m_sum = 0; m_carry = 0; m_ovf = 0;
    n_resp0 = 0; n_resp1 = 0;
    rst = 1; resp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

    // Reset state.
    repeat (3) step(1, 1);
    check_reset_outputs("reset");

    // Single requests with simple and carry/overflow operands.
    p0_v = 1; p0_a = 8'h01; p0_b = 8'h01;
    repeat (4) step(0, 1);
    p1_v = 1; p1_a = 8'hFF; p1_b = 8'h01;
    repeat (4) step(0, 1);
    p1_v = 1; p1_a = 8'h81; p1_b = 8'h81;
    repeat (4) step(0, 1);
    chk("single_resp_count", n_resp0 + n_resp1, 3);

    // Both requesters continuously valid after reset: alternating grants.
    step(1, 1);
    n_resp0 = 0; n_resp1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (!p0_v) begin p0_v = 1; p0_a = 8'h02; p0_b = 8'h03; end
      if (!p1_v) begin p1_v = 1; p1_a = 8'h19; p1_b = 8'h31; end
      step(0, 1);
    end
    chk("alt_resp0", n_resp0, 2);
    chk("alt_resp1", n_resp1, 2);

    // Backpressure with req1 pending.
    p0_v = 0; p1_v = 0;
    repeat (4) step(0, 1);
    p0_v = 1; p0_a = 8'h10; p0_b = 8'h20;
    step(0, 1);
    p1_v = 1; p1_a = 8'h05; p1_b = 8'h06;
    repeat (6) step(0, 0);
    repeat (5) step(0, 1);

    // Reset while executing: no response, then req0 wins contention.
    p0_v = 1; p0_a = 8'h44; p0_b = 8'h55;
    step(0, 1);
    step(1, 1);
    check_reset_outputs("midrst");
    p0_v = 1; p0_a = 8'h01; p0_b = 8'h02;
    p1_v = 1; p1_a = 8'h03; p1_b = 8'h04;
    repeat (8) step(0, 1);

    // Edge operand values.
    for (int i = 0; i < 4; i++) begin
      p0_v = 1; p0_a = edge_a[i]; p0_b = edge_b[i];
      repeat (4) step(0, 1);
    end

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      if (!p0_v && ($urandom_range(0, 2) == 0)) begin
        r0 = $urandom_range(0, 5);
        p0_v = 1;
        p0_a = (r0 < 4) ? edge_a[r0] : 8'($urandom);
        p0_b = 8'($urandom);
      end
      if (!p1_v && ($urandom_range(0, 2) == 0)) begin
        p1_v = 1; p1_a = 8'($urandom); p1_b = 8'($urandom);
      end
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adder_arbiter
`default_nettype wire
